// File: rtl/key_loader_if.sv
// Host-side byte stream and key-presentation bundle for key_loader.
// Latency: n/a (signal bundle only).
// Backpressure: ByteReady from the loader stalls ByteIn/ByteValid at the host.
//
// Ports:
//   ByteIn/ByteValid/ByteReady : serial key bytes, valid/ready handshake
//   KeyClear                   : synchronous drop-key / return-to-idle request
//   Key/ReadyKey/ByteCount     : assembled key, complete flag, bytes held
//   TimeoutErr                 : one-cycle pulse when a partial key is discarded
interface key_loader_if;
  logic [7:0]   ByteIn;
  logic         ByteValid;
  logic         ByteReady;
  logic         KeyClear;
  logic [127:0] Key;
  logic         ReadyKey;
  logic [4:0]   ByteCount;
  logic         TimeoutErr;

  // Host side: supplies bytes and clear requests, observes the key.
  modport master (
    output ByteIn, ByteValid, KeyClear,
    input  ByteReady, Key, ReadyKey, ByteCount, TimeoutErr
  );

  // Loader side.
  modport slave (
    input  ByteIn, ByteValid, KeyClear,
    output ByteReady, Key, ReadyKey, ByteCount, TimeoutErr
  );
endinterface

// File: rtl/key_loader.sv
// Assembles a 128-bit AES key from 16 serial host bytes; ReadyKey gates key expansion.
// Latency: 1 byte/cycle; ReadyKey rises the cycle after the 16th accepted byte.
// Backpressure: ByteReady drops while a complete key is held; bytes stall, never drop.
//
// Ports:
//   Clk  : system clock, rising edge
//   Rst  : asynchronous active-low reset
//   bus  : key_loader_if.slave (byte handshake, KeyClear, Key/ReadyKey/ByteCount/TimeoutErr)
// Parameter TIMEOUT: max idle cycles between accepts while loading (0 = never time out).
module key_loader #(
  parameter int TIMEOUT = 100000
) (
  input  logic          Clk,
  input  logic          Rst,
  key_loader_if.slave   bus
);

  // Idle counter is at least one bit wide so TIMEOUT=0 still elaborates.
  localparam int CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_READY = 2'd2
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [127:0]  r_key,   w_key_nxt;
  logic [4:0]    r_cnt,   w_cnt_nxt;
  logic [CW-1:0] r_idle,  w_idle_nxt;
  logic          r_terr,  w_terr_nxt;

  logic          w_byte_rdy;
  logic          w_accept;
  logic          w_tmo_hit;

  // Ready is a pure state decode so it never combinationally follows ByteValid.
  assign w_byte_rdy = (r_state != S_READY);
  assign w_accept   = bus.ByteValid && w_byte_rdy;
  // The edge that would make the idle count equal TIMEOUT is the timeout edge.
  assign w_tmo_hit  = (TIMEOUT != 0) && (r_idle == TMO_LAST);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= S_IDLE;
      r_key   <= '0;
      r_cnt   <= '0;
      r_idle  <= '0;
      r_terr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_key   <= w_key_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idle  <= w_idle_nxt;
      r_terr  <= w_terr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_key_nxt   = r_key;
    w_cnt_nxt   = r_cnt;
    w_idle_nxt  = r_idle;
    w_terr_nxt  = 1'b0;

    // KeyClear overrides everything, including a byte accepted in the same cycle
    // and a timeout that would otherwise fire.
    if (bus.KeyClear) begin
      w_state_nxt = S_IDLE;
      w_key_nxt   = '0;
      w_cnt_nxt   = '0;
      w_idle_nxt  = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            w_key_nxt   = {r_key[119:0], bus.ByteIn};
            w_cnt_nxt   = 5'd1;
            w_idle_nxt  = '0;
            w_state_nxt = S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            // An accept on the timeout edge wins and restarts the idle count.
            w_key_nxt  = {r_key[119:0], bus.ByteIn};
            w_cnt_nxt  = r_cnt + 5'd1;
            w_idle_nxt = '0;
            if (r_cnt == 5'd15) begin
              w_state_nxt = S_READY;
            end
          end else if (w_tmo_hit) begin
            w_state_nxt = S_IDLE;
            w_key_nxt   = '0;
            w_cnt_nxt   = '0;
            w_idle_nxt  = '0;
            w_terr_nxt  = 1'b1;
          end else if (r_idle != '1) begin
            w_idle_nxt = r_idle + CW'(1);
          end
        end
        S_READY: begin
          // Key frozen until KeyClear.
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_key_nxt   = '0;
          w_cnt_nxt   = '0;
          w_idle_nxt  = '0;
        end
      endcase
    end
  end

  assign bus.ByteReady  = w_byte_rdy;
  assign bus.ReadyKey   = (r_state == S_READY);
  assign bus.Key        = r_key;
  assign bus.ByteCount  = r_cnt;
  assign bus.TimeoutErr = r_terr;

endmodule

// File: tb/tb_key_loader.sv
// Self-checking bench for key_loader with TIMEOUT=8.
// Latency: n/a.
// Backpressure: n/a.
module tb_key_loader;
  localparam int TMO = 8;

  logic Clk = 1'b0;
  logic Rst = 1'b0;

  key_loader_if bus ();

  key_loader #(.TIMEOUT(TMO)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  int n_pass  = 0;
  int n_total = 0;
  int pulses  = 0;
  bit done    = 1'b0;

  // Model: the list of bytes held for the current key, cycles since last accept,
  // and whether a timeout discard happened on the most recent edge.
  logic [7:0] m_bytes [16];
  int         m_n    = 0;
  int         m_gap  = 0;
  bit         m_terr = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Key is right-aligned: newest byte in [7:0], oldest byte highest.
  function automatic logic [127:0] model_key();
    logic [127:0] k;
    k = '0;
    for (int i = 0; i < m_n; i++) k[8*(m_n-1-i) +: 8] = m_bytes[i];
    return k;
  endfunction

  always @(negedge Rst) begin
    m_n = 0; m_gap = 0; m_terr = 1'b0;
  end

  always @(posedge Clk) begin
    if (Rst) begin
      m_terr = 1'b0;
      if (bus.KeyClear) begin
        m_n = 0; m_gap = 0;
      end else if (bus.ByteValid && m_n < 16) begin
        m_bytes[m_n] = bus.ByteIn;
        m_n++;
        m_gap = 0;
      end else if (m_n > 0 && m_n < 16) begin
        m_gap++;
        if (TMO != 0 && m_gap == TMO) begin
          m_n = 0; m_gap = 0; m_terr = 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge Clk) begin
    if (!done) begin
      check("Key",        bus.Key,                 model_key());
      check("ByteCount",  128'(bus.ByteCount),     128'(m_n));
      check("ReadyKey",   128'(bus.ReadyKey),      128'(m_n == 16));
      check("ByteReady",  128'(bus.ByteReady),     128'(m_n < 16));
      check("TimeoutErr", 128'(bus.TimeoutErr),    128'(m_terr));
      if (bus.TimeoutErr === 1'b1) pulses++;
    end
  end

  // Hold the given inputs across one rising edge; returns at the next falling edge.
  task automatic step(input logic v, input logic [7:0] b, input logic c);
    bus.ByteValid = v;
    bus.ByteIn    = b;
    bus.KeyClear  = c;
    @(negedge Clk);
  endtask

  logic [7:0] fips [16];

  initial begin
    fips = '{8'h2b, 8'h7e, 8'h15, 8'h16, 8'h28, 8'hae, 8'hd2, 8'ha6,
             8'hab, 8'hf7, 8'h15, 8'h88, 8'h09, 8'hcf, 8'h4f, 8'h3c};
    bus.ByteValid = 1'b0;
    bus.ByteIn    = 8'h00;
    bus.KeyClear  = 1'b0;

    // Reset values
    #2;
    check("rst_Key",        bus.Key,                 128'h0);
    check("rst_ByteCount",  128'(bus.ByteCount),     128'd0);
    check("rst_ReadyKey",   128'(bus.ReadyKey),      128'd0);
    check("rst_ByteReady",  128'(bus.ByteReady),     128'd1);
    check("rst_TimeoutErr", 128'(bus.TimeoutErr),    128'd0);
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);

    // 16 back-to-back bytes 00..0F
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0);
    #1;
    check("t1_Key",       bus.Key,             128'h000102030405060708090A0B0C0D0E0F);
    check("t1_ReadyKey",  128'(bus.ReadyKey),  128'd1);
    check("t1_ByteCount", 128'(bus.ByteCount), 128'd16);
    check("t1_ByteReady", 128'(bus.ByteReady), 128'd0);

    // Bytes stall while the key is held; KeyClear releases them.
    repeat (5) step(1'b1, 8'hAA, 1'b0);
    #1;
    check("t2_Key_frozen", bus.Key, 128'h000102030405060708090A0B0C0D0E0F);
    step(1'b1, 8'hAA, 1'b1);
    #1;
    check("t2_clr_ReadyKey",  128'(bus.ReadyKey),  128'd0);
    check("t2_clr_Key",       bus.Key,             128'h0);
    check("t2_clr_ByteCount", 128'(bus.ByteCount), 128'd0);
    step(1'b1, 8'hAA, 1'b0);
    #1;
    check("t2_first_Key",   bus.Key,             128'hAA);
    check("t2_first_Count", 128'(bus.ByteCount), 128'd1);
    step(1'b0, 8'h00, 1'b1);

    // Timeout: 3 bytes then idle
    pulses = 0;
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    repeat (7) step(1'b0, 8'h00, 1'b0);
    #1;
    check("t3_before_Count", 128'(bus.ByteCount),  128'd3);
    check("t3_before_Key",   bus.Key,              128'h112233);
    check("t3_before_Terr",  128'(bus.TimeoutErr), 128'd0);
    step(1'b0, 8'h00, 1'b0);
    #1;
    check("t3_Terr",  128'(bus.TimeoutErr), 128'd1);
    check("t3_Count", 128'(bus.ByteCount),  128'd0);
    check("t3_Key",   bus.Key,              128'h0);
    repeat (10) step(1'b0, 8'h00, 1'b0);
    #1;
    check("t3_pulses", 128'(pulses), 128'd1);

    // FIPS-197 key with 7-cycle gaps: no timeout
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, fips[i], 1'b0);
      if (i != 15) repeat (7) step(1'b0, 8'h00, 1'b0);
    end
    #1;
    check("t4_Key",      bus.Key,            128'h2b7e151628aed2a6abf7158809cf4f3c);
    check("t4_ReadyKey", 128'(bus.ReadyKey), 128'd1);
    check("t4_pulses",   128'(pulses),       128'd0);
    step(1'b0, 8'h00, 1'b1);

    // KeyClear together with the 10th byte
    for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
    step(1'b1, 8'h49, 1'b1);
    #1;
    check("t5_Count", 128'(bus.ByteCount), 128'd0);
    check("t5_Key",   bus.Key,             128'h0);
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'hF0 + i), 1'b0);
    #1;
    check("t5_full_Key",   bus.Key,            128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF);
    check("t5_full_Ready", 128'(bus.ReadyKey), 128'd1);
    step(1'b0, 8'h00, 1'b1);

    // Asynchronous reset mid-load, between clock edges
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h80 + i), 1'b0);
    bus.ByteValid = 1'b1;
    bus.ByteIn    = 8'h88;
    #2;
    Rst = 1'b0;
    #1;
    check("t6_Key",       bus.Key,             128'h0);
    check("t6_Count",     128'(bus.ByteCount), 128'd0);
    check("t6_ReadyKey",  128'(bus.ReadyKey),  128'd0);
    check("t6_ByteReady", 128'(bus.ByteReady), 128'd1);
    bus.ByteValid = 1'b0;
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
    #1;
    check("t6_full_Key",   bus.Key,            128'h101112131415161718191A1B1C1D1E1F);
    check("t6_full_Ready", 128'(bus.ReadyKey), 128'd1);
    step(1'b0, 8'h00, 1'b0);

    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/key_loader.md
# key_loader

Collects a 128-bit AES cipher key as 16 serial bytes from the host byte stream (UART receive path) and presents it as a parallel word with a level `ReadyKey` flag. Sits directly upstream of the key-reset logic: `ReadyKey` low holds the key schedule in reset, and its rising edge releases key expansion on a stable `Key`. Includes byte backpressure, an abort/reload request and an inter-byte timeout that discards partial keys.

## Interface

- `TIMEOUT`, 100000, max idle cycles between accepted bytes while loading; 0 disables timeout
- `Clk`  in  1  system clock, all logic rising-edge
- `Rst`  in  1  asynchronous, active-low reset
- `ByteIn`  in  8  key byte from host
- `ByteValid`  in  1  `ByteIn` valid this cycle
- `ByteReady`  out  1  loader accepts a byte this cycle
- `KeyClear`  in  1  synchronous request: drop current/finished key, return to IDLE
- `Key`  out  128  assembled key; first byte received in `Key[127:120]`, 16th in `Key[7:0]`
- `ReadyKey`  out  1  level, high while a complete key is held
- `ByteCount`  out  5  bytes accepted for current key, 0..16
- `TimeoutErr`  out  1  one-cycle pulse when a partial key is discarded by timeout

## Operation

- Byte accepted iff `ByteValid && ByteReady` on a rising edge.
- Accept: `Key <= {Key[119:0], ByteIn}`, `ByteCount <= ByteCount + 1`, idle counter cleared.
- States:
  - IDLE: `ByteReady`=1, `ByteCount`=0, `Key`=0. Accepted byte -> LOAD (count 1).
  - LOAD: `ByteReady`=1. Accepted byte with `ByteCount`==15 -> READY (count 16). Idle counter increments every cycle without an accept; reaching `TIMEOUT` (if nonzero) -> IDLE, `Key` and `ByteCount` cleared, `TimeoutErr` pulses.
  - READY: `ByteReady`=0 (bytes stalled, not dropped), `ReadyKey`=1, `Key` frozen, `ByteCount`=16. Stays until `KeyClear`.
- `KeyClear` in any state: next cycle IDLE, `Key`=0, `ByteCount`=0, `ReadyKey`=0, idle counter 0. No `TimeoutErr`.
- `KeyClear` and accepted byte same cycle: `KeyClear` wins, byte discarded (upstream sees it accepted).
- Timeout and accept same cycle: accept wins, counter cleared.
- Timeout and `KeyClear` same cycle: `KeyClear` wins, no `TimeoutErr`.
- Idle counter width `$clog2(TIMEOUT+1)`, saturates; never wraps.
- `ByteCount` never exceeds 16; no wrap from 16 to 0 except via `KeyClear`/reset.

## Timing

- Reset (`Rst`=0, async): state IDLE, `Key`=0, `ByteCount`=0, `ReadyKey`=0, `TimeoutErr`=0, `ByteReady`=1 after reset releases; idle counter 0.
- `ByteReady` is a registered-state decode: combinational from state only, never from `ByteValid`.
- `ReadyKey` rises the cycle after the 16th accept; `Key` already final in that same cycle.
- `ReadyKey` falls the cycle after `KeyClear` sampled high.
- Timeout fires on the edge where idle count reaches `TIMEOUT` cycles since the last accept; `TimeoutErr` high exactly one cycle, coincident with state = IDLE.
- Back-to-back bytes: 1 byte/cycle; 16-cycle minimum load, `ReadyKey` at cycle 17.
- Reset mid-load: all outputs to reset values immediately, partial key lost.

## Test plan

- Reset then 16 back-to-back bytes 0x00,0x01..0x0F -> `ReadyKey`=1 one cycle after last byte, `Key`=128'h000102030405060708090A0B0C0D0E0F, `ByteCount`=16, `ByteReady`=0.
- With `ReadyKey`=1, hold `ByteValid`=1 `ByteIn`=0xAA for 5 cycles -> no accept, `Key` unchanged; assert `KeyClear` -> next cycle `ReadyKey`=0, `Key`=0, `ByteCount`=0, then 0xAA accepted as first byte.
- `TIMEOUT`=8: send 3 bytes, then idle -> after 8 idle cycles `TimeoutErr` pulses once, `ByteCount`=0, `Key`=0; idle in IDLE produces no further pulses.
- `TIMEOUT`=8: 16 bytes with 7-cycle gaps -> no `TimeoutErr`, `ReadyKey`=1 with correct key (FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c).
- `KeyClear` asserted together with 10th byte -> byte dropped, `ByteCount`=0 next cycle; subsequent 16 bytes load cleanly.
- Drop `Rst` low mid-load at byte 9 (asynchronously, between edges) -> outputs to reset values without waiting for clock edge; after release, full key loads normally.
